// File: rtl/vga_frame_monitor_pkg.sv
// Shared constants for the VGA stream path and the frame monitor.
//   VGA_RES_H / VGA_RES_V : active geometry of the display mode
//   COLOR_*               : RRRGGGBB colour constants
//   mon_state_t           : frame monitor lock states
package vga_frame_monitor_pkg;

    localparam int VGA_RES_H = 640;
    localparam int VGA_RES_V = 480;

    localparam logic [7:0] COLOR_BLACK = 8'h00;
    localparam logic [7:0] COLOR_WHITE = 8'hFF;
    localparam logic [7:0] COLOR_RED   = 8'hE0;
    localparam logic [7:0] COLOR_GREEN = 8'h1C;
    localparam logic [7:0] COLOR_BLUE  = 8'h03;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_ACQUIRE = 2'd1,
        MON_LOCKED  = 2'd2
    } mon_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vga_frame_monitor_stream_delay.sv
// stream_delay: LAG-deep shift register used to line the sync/qualifier
// bits up with a pixel bus that arrives LAG cycles later.
//   clk, arst_n : pixel clock, asynchronous active-low reset
//   d           : WIDTH-bit input sampled every cycle
//   q           : d delayed by LAG cycles (combinational pass-through if LAG==0)
module stream_delay #(
    parameter int WIDTH = 2,
    parameter int LAG   = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (LAG == 0) begin : g_bypass
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [LAG];

            // NOTE: this array is only a few flops deep, so it is reset like
            // any register; large RAM-style arrays would be left unreset.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    for (int i = 0; i < LAG; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < LAG; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[LAG-1];
        end
    endgenerate

endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: receive-side checker for the VGA pixel stream.
// Rebuilds pixel coordinates from vsync/data_enable, verifies each frame is
// exactly RES_H x RES_V, counts nonzero pixels and captures one probe pixel.
//   clk, arst_n          : pixel clock, asynchronous active-low reset
//   vsync, data_enable   : timing inputs (PIXEL_LAG cycles ahead of vga_in)
//   vga_in               : RRRGGGBB pixel
//   probe_x, probe_y     : capture coordinate, changed between frames
//   locked               : at least one good frame since the last bad one
//   frame_done/error     : one-cycle verdict pulses at each frame boundary
//   error_count          : saturating bad-frame count
//   lit_count            : nonzero pixels in the last good frame
//   probe_pixel/valid    : pixel at the probe coordinate in the last good frame
module vga_frame_monitor
    import vga_frame_monitor_pkg::*;
#(
    parameter int RES_H            = VGA_RES_H,
    parameter int RES_V            = VGA_RES_V,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    parameter int PIXEL_LAG        = 1
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               vsync,
    input  logic                               data_enable,
    input  logic [7:0]                         vga_in,
    input  logic [$clog2(RES_H)-1:0]           probe_x,
    input  logic [$clog2(RES_V)-1:0]           probe_y,
    output logic                               locked,
    output logic                               frame_done,
    output logic                               frame_error,
    output logic [7:0]                         error_count,
    output logic [$clog2(RES_H*RES_V+1)-1:0]   lit_count,
    output logic [7:0]                         probe_pixel,
    output logic                               probe_valid
);

    localparam int XW = $clog2(RES_H + 2);
    localparam int YW = $clog2(RES_V + 2);
    localparam int LW = $clog2(RES_H * RES_V + 1);

    localparam logic [XW-1:0] X_FULL = XW'(RES_H);
    localparam logic [XW-1:0] X_SAT  = XW'(RES_H + 1);
    localparam logic [YW-1:0] Y_FULL = YW'(RES_V);
    localparam logic [YW-1:0] Y_SAT  = YW'(RES_V + 1);

    logic [1:0] sync_q;
    logic       vs, de;

    stream_delay #(.WIDTH(2), .LAG(PIXEL_LAG)) u_stream_delay (
        .clk    (clk),
        .arst_n (arst_n),
        .d      ({vsync, data_enable}),
        .q      (sync_q)
    );

    assign vs = sync_q[1];
    assign de = sync_q[0];

    mon_state_t     state_q, state_d;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;
    logic           line_bad_q, de_in_vs_q, de_q, vs_act_q;
    logic [LW-1:0]  lit_run_q;
    logic [7:0]     probe_run_q;

    logic           vs_act, boundary, de_fall, line_short, frame_good, at_probe;
    logic [YW-1:0]  y_inc, y_end;

    assign vs_act     = VSYNC_ACTIVE_LOW ? ~vs : vs;
    assign boundary   = vs_act & ~vs_act_q;
    assign de_fall    = de_q & ~de;
    assign line_short = de_fall && (x_q != X_FULL);
    assign y_inc      = (y_q == Y_SAT) ? y_q : y_q + 1'b1;
    // A line ending in the boundary cycle still belongs to the closing frame.
    assign y_end      = de_fall ? y_inc : y_q;
    assign frame_good = (y_end == Y_FULL) && !(line_bad_q || line_short)
                     && !(de_in_vs_q || (de && vs_act));
    assign at_probe   = (x_q == XW'(probe_x)) && (y_q == YW'(probe_y));

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            MON_IDLE:    if (boundary)               state_d = MON_ACQUIRE;
            MON_ACQUIRE: if (boundary && frame_good) state_d = MON_LOCKED;
            MON_LOCKED:  if (boundary && !frame_good) state_d = MON_ACQUIRE;
            default:                                 state_d = MON_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= MON_IDLE;
            de_q        <= 1'b0;
            // Treat vsync as already active so a sync pulse in flight at
            // reset release cannot fake a boundary.
            vs_act_q    <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            line_bad_q  <= 1'b0;
            de_in_vs_q  <= 1'b0;
            lit_run_q   <= '0;
            probe_run_q <= '0;
        end else begin
            state_q  <= state_d;
            de_q     <= de;
            vs_act_q <= vs_act;
            if (boundary) begin
                x_q         <= '0;
                y_q         <= '0;
                line_bad_q  <= 1'b0;
                de_in_vs_q  <= 1'b0;
                lit_run_q   <= '0;
                probe_run_q <= '0;
            end else begin
                if (de) begin
                    x_q <= (x_q == X_SAT) ? x_q : x_q + 1'b1;
                    if (vga_in != 8'h00 && lit_run_q != '1) lit_run_q <= lit_run_q + 1'b1;
                    if (at_probe) probe_run_q <= vga_in;
                    if (vs_act) de_in_vs_q <= 1'b1;
                end
                if (de_fall) begin
                    x_q <= '0;
                    y_q <= y_inc;
                    if (line_short) line_bad_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            error_count <= '0;
            lit_count   <= '0;
            probe_pixel <= '0;
            probe_valid <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (boundary && state_q != MON_IDLE) begin
                if (frame_good) begin
                    frame_done  <= 1'b1;
                    lit_count   <= lit_run_q;
                    probe_pixel <= probe_run_q;
                    probe_valid <= 1'b1;
                end else begin
                    frame_error <= 1'b1;
                    error_count <= sat_inc8(error_count);
                end
            end
        end
    end

    assign locked = (state_q == MON_LOCKED);

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a reduced 16x8 geometry.
// Frames are driven as: lines (16 de-high + 4 blank), 2 front-porch cycles,
// 2-cycle active-low vsync, 3 back-porch cycles. vga_in lags data_enable by 1.
module tb_vga_frame_monitor;

    localparam int H = 16;
    localparam int V = 8;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       vsync, data_enable;
    logic [7:0] vga_in;
    logic [3:0] probe_x;
    logic [2:0] probe_y;
    logic       locked, frame_done, frame_error;
    logic [7:0] error_count, probe_pixel;
    logic [7:0] lit_count;
    logic       probe_valid;

    vga_frame_monitor #(
        .RES_H(H), .RES_V(V), .VSYNC_ACTIVE_LOW(1'b1), .PIXEL_LAG(1)
    ) dut (
        .clk(clk), .arst_n(arst_n), .vsync(vsync), .data_enable(data_enable),
        .vga_in(vga_in), .probe_x(probe_x), .probe_y(probe_y),
        .locked(locked), .frame_done(frame_done), .frame_error(frame_error),
        .error_count(error_count), .lit_count(lit_count),
        .probe_pixel(probe_pixel), .probe_valid(probe_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse observer: only counts events, comparisons live in the tasks.
    int   done_cnt = 0, err_cnt = 0;
    bit   both_seen = 0, b2b_seen = 0;
    logic pulse_q = 1'b0;
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_error) err_cnt++;
        if (frame_done && frame_error) both_seen = 1;
        if ((frame_done || frame_error) && pulse_q) b2b_seen = 1;
        pulse_q = frame_done || frame_error;
    end

    // Pixel pattern: 0 black, 1 rectangle of blk_color, 2 blue checkerboard
    int         pat_mode = 0;
    int         bx, by, bw, bh;
    logic [7:0] blk_color;
    logic [7:0] pix_d = 8'h00;

    function automatic logic [7:0] pix(input int c, input int r);
        case (pat_mode)
            1:       return (c >= bx && c < bx + bw && r >= by && r < by + bh) ? blk_color : 8'h00;
            2:       return ((c + r) % 2 == 1) ? 8'h03 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick(input logic vs, input logic de, input logic [7:0] p);
        @(negedge clk);
        vsync       = vs;
        data_enable = de;
        vga_in      = pix_d;
        pix_d       = p;
    endtask

    // Rows first..first+count-1; row short_row gets short_len pixels instead of H.
    task automatic send_lines(input int first, input int count, input int short_row, input int short_len);
        for (int r = first; r < first + count; r++) begin
            int len = (r == short_row) ? short_len : H;
            for (int c = 0; c < len; c++) tick(1'b1, 1'b1, pix(c, r));
            for (int b = 0; b < 4; b++) tick(1'b1, 1'b0, 8'h00);
        end
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
    endtask

    // Frame boundary. overlap=1 starts row 0 during the second vsync cycle.
    task automatic vsync_pulse(input bit overlap);
        tick(1'b0, 1'b0, 8'h00);
        if (overlap) begin
            tick(1'b0, 1'b1, pix(0, 0));
            for (int c = 1; c < H; c++) tick(1'b1, 1'b1, pix(c, 0));
            for (int b = 0; b < 4; b++) tick(1'b1, 1'b0, 8'h00);
        end else begin
            tick(1'b0, 1'b0, 8'h00);
            for (int b = 0; b < 3; b++) tick(1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic frame(input int lines, input int short_row, input int short_len);
        send_lines(0, lines, short_row, short_len);
        vsync_pulse(1'b0);
    endtask

    task automatic test_reset();
        arst_n = 1'b0; vsync = 1'b1; data_enable = 1'b0; vga_in = 8'h00;
        probe_x = 4'd0; probe_y = 3'd0;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        n_cmp++; if (locked !== 1'b0)       begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (frame_done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_cmp++; if (frame_error !== 1'b0)  begin n_bad++; $display("FAIL reset_error: got %b want 0", frame_error); end
        n_cmp++; if (error_count !== 8'd0)  begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", error_count); end
        n_cmp++; if (lit_count !== 8'd0)    begin n_bad++; $display("FAIL reset_lit: got %0d want 0", lit_count); end
        n_cmp++; if (probe_pixel !== 8'h00) begin n_bad++; $display("FAIL reset_probe: got %h want 00", probe_pixel); end
        n_cmp++; if (probe_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_pvalid: got %b want 0", probe_valid); end
    endtask

    task automatic test_clean_frames();
        int d0 = done_cnt, e0 = err_cnt;
        pat_mode = 0;
        frame(V, -1, 0);
        n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL clean1_done: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (locked !== 1'b0)     begin n_bad++; $display("FAIL clean1_locked: got %b want 0", locked); end
        frame(V, -1, 0);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL clean2_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (err_cnt - e0 !== 0)  begin n_bad++; $display("FAIL clean_errors: got %0d want 0", err_cnt - e0); end
        n_cmp++; if (locked !== 1'b1)     begin n_bad++; $display("FAIL clean2_locked: got %b want 1", locked); end
        n_cmp++; if (lit_count !== 8'd0)  begin n_bad++; $display("FAIL clean2_lit: got %0d want 0", lit_count); end
        n_cmp++; if (probe_valid !== 1'b1) begin n_bad++; $display("FAIL clean2_pvalid: got %b want 1", probe_valid); end
    endtask

    task automatic test_lit_patterns();
        // 5x3 white block at (4,2), probe inside it
        pat_mode = 1; bx = 4; by = 2; bw = 5; bh = 3; blk_color = 8'hFF;
        probe_x = 4'd5; probe_y = 3'd3;
        frame(V, -1, 0);
        n_cmp++; if (lit_count !== 8'd15)   begin n_bad++; $display("FAIL block_lit: got %0d want 15", lit_count); end
        n_cmp++; if (probe_pixel !== 8'hFF) begin n_bad++; $display("FAIL block_probe: got %h want ff", probe_pixel); end
        n_cmp++; if (probe_valid !== 1'b1)  begin n_bad++; $display("FAIL block_pvalid: got %b want 1", probe_valid); end
        // checkerboard, half the pixels blue
        pat_mode = 2; probe_x = 4'd1; probe_y = 3'd0;
        frame(V, -1, 0);
        n_cmp++; if (lit_count !== 8'd64)   begin n_bad++; $display("FAIL checker_lit: got %0d want 64", lit_count); end
        n_cmp++; if (probe_pixel !== 8'h03) begin n_bad++; $display("FAIL checker_probe: got %h want 03", probe_pixel); end
        // single green pixel at the last column of the last row
        pat_mode = 1; bx = 15; by = 7; bw = 1; bh = 1; blk_color = 8'h1C;
        probe_x = 4'd15; probe_y = 3'd7;
        frame(V, -1, 0);
        n_cmp++; if (lit_count !== 8'd1)    begin n_bad++; $display("FAIL corner_lit: got %0d want 1", lit_count); end
        n_cmp++; if (probe_pixel !== 8'h1C) begin n_bad++; $display("FAIL corner_probe: got %h want 1c", probe_pixel); end
        n_cmp++; if (locked !== 1'b1)       begin n_bad++; $display("FAIL corner_locked: got %b want 1", locked); end
    endtask

    task automatic test_line_errors();
        int d0, e0;
        // checker content would change lit_count if a bad frame were latched
        pat_mode = 2; probe_x = 4'd1; probe_y = 3'd0;
        e0 = err_cnt;
        frame(V, 3, H - 1);
        n_cmp++; if (err_cnt - e0 !== 1)    begin n_bad++; $display("FAIL short_pulse: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (locked !== 1'b0)       begin n_bad++; $display("FAIL short_locked: got %b want 0", locked); end
        n_cmp++; if (error_count !== 8'd1)  begin n_bad++; $display("FAIL short_errcnt: got %0d want 1", error_count); end
        n_cmp++; if (lit_count !== 8'd1)    begin n_bad++; $display("FAIL short_lit_held: got %0d want 1", lit_count); end
        n_cmp++; if (probe_pixel !== 8'h1C) begin n_bad++; $display("FAIL short_probe_held: got %h want 1c", probe_pixel); end
        pat_mode = 0; d0 = done_cnt;
        frame(V, -1, 0);
        n_cmp++; if (done_cnt - d0 !== 1)   begin n_bad++; $display("FAIL relock_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (locked !== 1'b1)       begin n_bad++; $display("FAIL relock_locked: got %b want 1", locked); end
        n_cmp++; if (lit_count !== 8'd0)    begin n_bad++; $display("FAIL relock_lit: got %0d want 0", lit_count); end
        e0 = err_cnt;
        frame(V, 2, H + 1);
        n_cmp++; if (err_cnt - e0 !== 1)    begin n_bad++; $display("FAIL long_pulse: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (error_count !== 8'd2)  begin n_bad++; $display("FAIL long_errcnt: got %0d want 2", error_count); end
        frame(V, -1, 0);
    endtask

    task automatic test_frame_errors();
        int d0, e0;
        pat_mode = 0;
        e0 = err_cnt;
        frame(V + 1, -1, 0);
        n_cmp++; if (err_cnt - e0 !== 1)   begin n_bad++; $display("FAIL tall_pulse: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (error_count !== 8'd3) begin n_bad++; $display("FAIL tall_errcnt: got %0d want 3", error_count); end
        // clean frame closed by a vsync that overlaps the next frame's row 0
        d0 = done_cnt; e0 = err_cnt;
        send_lines(0, V, -1, 0);
        vsync_pulse(1'b1);
        send_lines(1, V - 1, -1, 0);
        vsync_pulse(1'b0);
        n_cmp++; if (done_cnt - d0 !== 1)  begin n_bad++; $display("FAIL devs_prev_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (err_cnt - e0 !== 1)   begin n_bad++; $display("FAIL devs_pulse: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (error_count !== 8'd4) begin n_bad++; $display("FAIL devs_errcnt: got %0d want 4", error_count); end
        frame(V, -1, 0);
        n_cmp++; if (locked !== 1'b1)      begin n_bad++; $display("FAIL devs_relock: got %b want 1", locked); end
    endtask

    task automatic test_async_reset();
        int d0, e0;
        pat_mode = 2; probe_x = 4'd1; probe_y = 3'd0;
        frame(V, -1, 0);
        send_lines(0, V / 2, -1, 0);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        n_cmp++; if (locked !== 1'b0)       begin n_bad++; $display("FAIL arst_locked: got %b want 0", locked); end
        n_cmp++; if (error_count !== 8'd0)  begin n_bad++; $display("FAIL arst_errcnt: got %0d want 0", error_count); end
        n_cmp++; if (lit_count !== 8'd0)    begin n_bad++; $display("FAIL arst_lit: got %0d want 0", lit_count); end
        n_cmp++; if (probe_pixel !== 8'h00) begin n_bad++; $display("FAIL arst_probe: got %h want 00", probe_pixel); end
        n_cmp++; if (probe_valid !== 1'b0)  begin n_bad++; $display("FAIL arst_pvalid: got %b want 0", probe_valid); end
        repeat (2) tick(1'b1, 1'b0, 8'h00);
        arst_n = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        send_lines(V / 2, V / 2, -1, 0);
        vsync_pulse(1'b0);
        n_cmp++; if (done_cnt - d0 + err_cnt - e0 !== 0) begin n_bad++; $display("FAIL arst_first_boundary: got %0d pulses want 0", done_cnt - d0 + err_cnt - e0); end
        n_cmp++; if (locked !== 1'b0)       begin n_bad++; $display("FAIL arst_first_locked: got %b want 0", locked); end
        frame(V, -1, 0);
        n_cmp++; if (done_cnt - d0 !== 1)   begin n_bad++; $display("FAIL arst_second_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (locked !== 1'b1)       begin n_bad++; $display("FAIL arst_second_locked: got %b want 1", locked); end
        n_cmp++; if (lit_count !== 8'd64)   begin n_bad++; $display("FAIL arst_second_lit: got %0d want 64", lit_count); end
    endtask

    task automatic test_error_saturation();
        int e0 = err_cnt;
        // each bare vsync closes an empty (zero-line) frame
        for (int i = 0; i < 300; i++) vsync_pulse(1'b0);
        n_cmp++; if (err_cnt - e0 !== 300)   begin n_bad++; $display("FAIL sat_pulses: got %0d want 300", err_cnt - e0); end
        n_cmp++; if (error_count !== 8'd255) begin n_bad++; $display("FAIL sat_errcnt: got %0d want 255", error_count); end
        n_cmp++; if (locked !== 1'b0)        begin n_bad++; $display("FAIL sat_locked: got %b want 0", locked); end
    endtask

    task automatic test_pulse_rules();
        n_cmp++; if (both_seen !== 1'b0) begin n_bad++; $display("FAIL pulse_exclusive: got %b want 0", both_seen); end
        n_cmp++; if (b2b_seen !== 1'b0)  begin n_bad++; $display("FAIL pulse_back_to_back: got %b want 0", b2b_seen); end
    endtask

    initial begin
        test_reset();
        test_clean_frames();
        test_lit_patterns();
        test_line_errors();
        test_frame_errors();
        test_async_reset();
        test_error_saturation();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
